// File: rtl/regfile_mp_sb_pkg.sv
// Shared sizing constants for the multi-port register file with scoreboard.
package regfile_mp_sb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int IDXW_DEF = 5;
    localparam int NRD_DEF  = 2;
    localparam int NWR_DEF  = 2;
    localparam int X0_IDX   = 0;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Issue/read/writeback bundle between the pipeline and the register file.
interface regfile_mp_sb_if
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int IDXW = IDXW_DEF,
    parameter int NRD  = NRD_DEF,
    parameter int NWR  = NWR_DEF
) ();

    logic [NWR-1:0]      i_wen;
    logic [NWR*IDXW-1:0] i_widx;
    logic [NWR*XLEN-1:0] i_wdata;
    logic [NRD-1:0]      i_ren;
    logic [NRD*IDXW-1:0] i_ridx;
    logic [NRD*XLEN-1:0] o_rdata;
    logic [NRD-1:0]      o_rbusy;
    logic                i_issue_en;
    logic [IDXW-1:0]     i_issue_idx;
    logic                i_flush;
    logic [NREG-1:0]     o_busy_vec;

    modport master (
        output i_wen, i_widx, i_wdata, i_ren, i_ridx, i_issue_en, i_issue_idx, i_flush,
        input  o_rdata, o_rbusy, o_busy_vec
    );

    modport slave (
        input  i_wen, i_widx, i_wdata, i_ren, i_ridx, i_issue_en, i_issue_idx, i_flush,
        output o_rdata, o_rbusy, o_busy_vec
    );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy bits: flush beats issue, issue beats a same-cycle writeback clear.
module regfile_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int IDXW = IDXW_DEF,
    parameter int NWR  = NWR_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NWR-1:0]      i_wen,
    input  logic [NWR*IDXW-1:0] i_widx,
    input  logic                i_issue_en,
    input  logic [IDXW-1:0]     i_issue_idx,
    input  logic                i_flush,
    output logic [NREG-1:0]     o_busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (i_flush) begin
            busy_d = '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (i_wen[p]) begin
                    busy_d[i_widx[p*IDXW +: IDXW]] = 1'b0;
                end
            end
            // Applied after the clears so a newer producer of the same index stays pending.
            if (i_issue_en && (i_issue_idx != IDXW'(X0_IDX))) begin
                busy_d[i_issue_idx] = 1'b1;
            end
        end
        busy_d[X0_IDX] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port GPR file: storage, write arbitration, forwarding read muxes and read hazard flags.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int IDXW = IDXW_DEF,
    parameter int NRD  = NRD_DEF,
    parameter int NWR  = NWR_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    regfile_mp_sb_if.slave bus
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] busy_vec;
    logic [NRD*XLEN-1:0] rdata_flat;
    logic [NRD-1:0]      rbusy_flat;

    // Later ports overwrite earlier ones, so the highest-numbered port wins a collision.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NWR; p++) begin
            if (bus.i_wen[p] && (bus.i_widx[p*IDXW +: IDXW] != IDXW'(X0_IDX))) begin
                mem_d[bus.i_widx[p*IDXW +: IDXW]] = bus.i_wdata[p*XLEN +: XLEN];
            end
        end
        mem_d[X0_IDX] = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [IDXW-1:0] ridx;
            logic [XLEN-1:0] rdata;
            logic            fwd_hit;

            assign ridx = bus.i_ridx[gi*IDXW +: IDXW];

            always_comb begin
                rdata   = '0;
                fwd_hit = 1'b0;
                if (bus.i_ren[gi] && (ridx != IDXW'(X0_IDX))) begin
                    rdata = mem_q[ridx];
                    for (int p = 0; p < NWR; p++) begin
                        if (bus.i_wen[p] && (bus.i_widx[p*IDXW +: IDXW] == ridx)) begin
                            rdata   = bus.i_wdata[p*XLEN +: XLEN];
                            fwd_hit = 1'b1;
                        end
                    end
                end
            end

            assign rdata_flat[gi*XLEN +: XLEN] = rdata;
            // A same-cycle writeback of the source is forwarded, so it is not a hazard.
            assign rbusy_flat[gi] = bus.i_ren[gi] & (ridx != IDXW'(X0_IDX))
                                    & busy_vec[ridx] & ~fwd_hit;
        end
    endgenerate

    regfile_scoreboard #(
        .NREG (NREG),
        .IDXW (IDXW),
        .NWR  (NWR)
    ) u_scoreboard (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wen       (bus.i_wen),
        .i_widx      (bus.i_widx),
        .i_issue_en  (bus.i_issue_en),
        .i_issue_idx (bus.i_issue_idx),
        .i_flush     (bus.i_flush),
        .o_busy_vec  (busy_vec)
    );

    assign bus.o_rdata    = rdata_flat;
    assign bus.o_rbusy    = rbusy_flat;
    assign bus.o_busy_vec = busy_vec;

endmodule
